// File: rtl/axis_reg_slice_pkg.sv
// Shared types and helpers for the AXI4-Stream register slice.
// Holds the output-stage load selector and the default tkeep width rule.
package axis_reg_slice_pkg;

    typedef enum logic [1:0] {
        LOAD_NONE,
        LOAD_INPUT,
        LOAD_SKID
    } out_load_e;

    function automatic int keep_width_for(input int data_width);
        return (data_width / 8 > 0) ? data_width / 8 : 1;
    endfunction

endpackage

// File: rtl/ifc_axis.sv
// AXI4-Stream bundle carrying clock, active-low asynchronous reset and one link.
// Used on both sides of a stream block through the master/slave modports.
interface ifc_axis #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = 1,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 1
) (
    input logic clk,
    input logic rst
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        input  clk, rst,
        output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  clk, rst,
        input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axis_reg_slice.sv
// Full-throughput AXI4-Stream skid buffer: payload, valid and ready are all registered,
// so no combinational path crosses the slice in either direction.
module axis_reg_slice
    import axis_reg_slice_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = keep_width_for(DATA_WIDTH),
    parameter bit LAST_ENABLE = 1'b1,
    parameter bit ID_ENABLE   = 1'b0,
    parameter int ID_WIDTH    = 8,
    parameter bit DEST_ENABLE = 1'b0,
    parameter int DEST_WIDTH  = 8,
    parameter bit USER_ENABLE = 1'b1,
    parameter int USER_WIDTH  = 1
) (
    ifc_axis.slave  s_axis_ifc,
    ifc_axis.master m_axis_ifc
);
    localparam int USER_LSB      = 0;
    localparam int DEST_LSB      = USER_LSB + USER_WIDTH;
    localparam int ID_LSB        = DEST_LSB + DEST_WIDTH;
    localparam int LAST_LSB      = ID_LSB + ID_WIDTH;
    localparam int KEEP_LSB      = LAST_LSB + 1;
    localparam int DATA_LSB      = KEEP_LSB + KEEP_WIDTH;
    localparam int PAYLOAD_WIDTH = DATA_LSB + DATA_WIDTH;

    localparam logic [KEEP_WIDTH-1:0] KEEP_DEFAULT = '1;
    localparam logic                  LAST_DEFAULT = 1'b1;
    localparam logic [ID_WIDTH-1:0]   ID_DEFAULT   = '0;
    localparam logic [DEST_WIDTH-1:0] DEST_DEFAULT = '0;
    localparam logic [USER_WIDTH-1:0] USER_DEFAULT = '0;

    logic clk;
    logic rst;
    assign clk = s_axis_ifc.clk;
    assign rst = s_axis_ifc.rst;

    logic [PAYLOAD_WIDTH-1:0] in_payload;
    logic [PAYLOAD_WIDTH-1:0] out_payload;
    logic [PAYLOAD_WIDTH-1:0] skid_payload;
    logic                     out_valid;
    logic                     skid_valid;
    logic                     ready;
    logic                     ready_next;
    out_load_e                out_load;
    logic                     skid_load;

    assign in_payload = {s_axis_ifc.tdata, s_axis_ifc.tkeep, s_axis_ifc.tlast,
                         s_axis_ifc.tid, s_axis_ifc.tdest, s_axis_ifc.tuser};

    // Keep accepting while at least one of the two stages will still be free next cycle.
    assign ready_next = m_axis_ifc.tready
                      | (!skid_valid & (!out_valid | !s_axis_ifc.tvalid));

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        out_load  = LOAD_NONE;
        skid_load = 1'b0;
        if (ready) begin
            if (m_axis_ifc.tready || !out_valid) begin
                out_load = LOAD_INPUT;
            end else begin
                skid_load = 1'b1;
            end
        end else if (m_axis_ifc.tready) begin
            out_load = LOAD_SKID;
        end
    end

    // Refilling from skid copies skid_valid rather than forcing 1, so the idle
    // cycle straight after reset cannot present an empty skid as a beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready      <= 1'b0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            ready <= ready_next;
            case (out_load)
                LOAD_INPUT: out_valid <= s_axis_ifc.tvalid;
                LOAD_SKID: begin
                    out_valid  <= skid_valid;
                    skid_valid <= 1'b0;
                end
                default: ;
            endcase
            if (skid_load) begin
                skid_valid <= s_axis_ifc.tvalid;
            end
        end
    end

    // NOTE: payload registers carry no reset; only the valid/ready flags define state.
    always_ff @(posedge clk) begin
        case (out_load)
            LOAD_INPUT: out_payload <= in_payload;
            LOAD_SKID:  out_payload <= skid_payload;
            default: ;
        endcase
        if (skid_load) begin
            skid_payload <= in_payload;
        end
    end

    assign s_axis_ifc.tready = ready;
    assign m_axis_ifc.tvalid = out_valid;
    assign m_axis_ifc.tdata  = out_payload[DATA_LSB +: DATA_WIDTH];
    assign m_axis_ifc.tkeep  = KEEP_ENABLE ? out_payload[KEEP_LSB +: KEEP_WIDTH] : KEEP_DEFAULT;
    assign m_axis_ifc.tlast  = LAST_ENABLE ? out_payload[LAST_LSB] : LAST_DEFAULT;
    assign m_axis_ifc.tid    = ID_ENABLE ? out_payload[ID_LSB +: ID_WIDTH] : ID_DEFAULT;
    assign m_axis_ifc.tdest  = DEST_ENABLE ? out_payload[DEST_LSB +: DEST_WIDTH] : DEST_DEFAULT;
    assign m_axis_ifc.tuser  = USER_ENABLE ? out_payload[USER_LSB +: USER_WIDTH] : USER_DEFAULT;

endmodule

// File: tb/tb_axis_reg_slice.sv
// Scoreboard bench for axis_reg_slice: drivers push expected beats, per-DUT monitors
// pop and compare on every downstream transfer.
module tb_axis_reg_slice;

    localparam int N_RAND = 2048;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [7:0]  id;
        logic [7:0]  dest;
        logic        user;
        int          exp_edge;
    } beat_a_t;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
        logic         user;
    } beat_r_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    beat_a_t q_a[$];
    beat_a_t q_d[$];
    beat_r_t q_r[$];
    int      r_rcvd = 0;
    logic    r_last_seen = 1'b0;
    bit      r_rand_en = 1'b0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    ifc_axis #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)) a_s (.clk(clk), .rst(rst));
    ifc_axis #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)) a_m (.clk(clk), .rst(rst));
    ifc_axis #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)) d_s (.clk(clk), .rst(rst));
    ifc_axis #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)) d_m (.clk(clk), .rst(rst));
    ifc_axis #(.DATA_WIDTH(128), .KEEP_WIDTH(16), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)) r_s (.clk(clk), .rst(rst));
    ifc_axis #(.DATA_WIDTH(128), .KEEP_WIDTH(16), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)) r_m (.clk(clk), .rst(rst));

    axis_reg_slice #(
        .DATA_WIDTH(32), .KEEP_ENABLE(1'b1), .KEEP_WIDTH(4), .LAST_ENABLE(1'b1),
        .ID_ENABLE(1'b1), .ID_WIDTH(8), .DEST_ENABLE(1'b1), .DEST_WIDTH(8),
        .USER_ENABLE(1'b1), .USER_WIDTH(1)
    ) dut_a (
        .s_axis_ifc(a_s),
        .m_axis_ifc(a_m)
    );

    axis_reg_slice #(
        .DATA_WIDTH(32), .KEEP_ENABLE(1'b0), .KEEP_WIDTH(4), .LAST_ENABLE(1'b0),
        .ID_ENABLE(1'b0), .ID_WIDTH(8), .DEST_ENABLE(1'b0), .DEST_WIDTH(8),
        .USER_ENABLE(1'b0), .USER_WIDTH(1)
    ) dut_d (
        .s_axis_ifc(d_s),
        .m_axis_ifc(d_m)
    );

    axis_reg_slice #(
        .DATA_WIDTH(128)
    ) dut_r (
        .s_axis_ifc(r_s),
        .m_axis_ifc(r_m)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [127:0] got);
        checks++;
        errors++;
        $display("FAIL %s got=%0h exp=<none> (t=%0t)", name, got, $time);
    endtask

    function automatic beat_a_t make_a(input logic [31:0] data, input logic [3:0] keep, input logic last,
                                       input logic [7:0] id, input logic [7:0] dest, input logic user);
        beat_a_t b;
        b.data = data; b.keep = keep; b.last = last;
        b.id = id; b.dest = dest; b.user = user; b.exp_edge = 0;
        return b;
    endfunction

    task automatic cmp_beat(input string tag, input beat_a_t got, input beat_a_t exp);
        check({tag, "_tdata"}, got.data, exp.data);
        check({tag, "_tkeep"}, got.keep, exp.keep);
        check({tag, "_tlast"}, got.last, exp.last);
        check({tag, "_tid"},   got.id,   exp.id);
        check({tag, "_tdest"}, got.dest, exp.dest);
        check({tag, "_tuser"}, got.user, exp.user);
    endtask

    // Drivers are entered just after a rising edge; acceptance is sampled on the falling edge.
    task automatic send_a(input beat_a_t b, input bit timed);
        a_s.tdata = b.data; a_s.tkeep = b.keep; a_s.tlast = b.last;
        a_s.tid = b.id; a_s.tdest = b.dest; a_s.tuser = b.user;
        a_s.tvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (a_s.tready === 1'b1) begin
                b.exp_edge = timed ? cyc + 2 : 0;
                q_a.push_back(b);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        fail_now("a_accept_timeout", b.data);
    endtask

    task automatic send_d(input beat_a_t b, input beat_a_t exp);
        d_s.tdata = b.data; d_s.tkeep = b.keep; d_s.tlast = b.last;
        d_s.tid = b.id; d_s.tdest = b.dest; d_s.tuser = b.user;
        d_s.tvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (d_s.tready === 1'b1) begin
                q_d.push_back(exp);
                @(posedge clk); #1;
                d_s.tvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        d_s.tvalid = 1'b0;
        fail_now("d_accept_timeout", b.data);
    endtask

    task automatic send_r(input beat_r_t b);
        r_s.tdata = b.data; r_s.tkeep = b.keep; r_s.tlast = b.last; r_s.tuser = b.user;
        r_s.tid = 8'($urandom); r_s.tdest = 8'($urandom);
        r_s.tvalid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (r_s.tready === 1'b1) begin
                q_r.push_back(b);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        fail_now("r_accept_timeout", b.data);
    endtask

    task automatic wait_drained(input string name);
        for (int n = 0; n < 500; n++) begin
            if (q_a.size() == 0 && q_d.size() == 0 && q_r.size() == 0) return;
            @(posedge clk); #1;
        end
        fail_now(name, 128'(q_a.size() + q_d.size() + q_r.size()));
    endtask

    initial forever begin
        beat_a_t got;
        beat_a_t exp;
        @(negedge clk);
        if (rst === 1'b1 && a_m.tvalid === 1'b1 && a_m.tready === 1'b1) begin
            got = make_a(a_m.tdata, a_m.tkeep, a_m.tlast, a_m.tid, a_m.tdest, a_m.tuser);
            if (q_a.size() == 0) begin
                fail_now("a_unexpected_beat", got.data);
            end else begin
                exp = q_a.pop_front();
                cmp_beat("a", got, exp);
                if (exp.exp_edge != 0) check("a_latency_edge", 128'(cyc + 1), 128'(exp.exp_edge));
            end
        end
    end

    initial forever begin
        beat_a_t got;
        @(negedge clk);
        if (rst === 1'b1 && d_m.tvalid === 1'b1 && d_m.tready === 1'b1) begin
            got = make_a(d_m.tdata, d_m.tkeep, d_m.tlast, d_m.tid, d_m.tdest, d_m.tuser);
            if (q_d.size() == 0) fail_now("d_unexpected_beat", got.data);
            else cmp_beat("d", got, q_d.pop_front());
        end
    end

    initial forever begin
        beat_r_t exp;
        @(negedge clk);
        if (rst === 1'b1 && r_m.tvalid === 1'b1 && r_m.tready === 1'b1) begin
            if (q_r.size() == 0) begin
                fail_now("r_unexpected_beat", r_m.tdata);
            end else begin
                exp = q_r.pop_front();
                r_rcvd++;
                r_last_seen = r_m.tlast;
                check("r_tdata", r_m.tdata, exp.data);
                check("r_tkeep", r_m.tkeep, exp.keep);
                check("r_tlast", r_m.tlast, exp.last);
                check("r_tuser", r_m.tuser, exp.user);
                check("r_tid_tdest_zero", {r_m.tid, r_m.tdest}, 16'h0);
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (r_rand_en) r_m.tready = 1'($urandom_range(0, 1));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        beat_r_t rb;
        a_s.tvalid = 1'b0; a_s.tdata = '0; a_s.tkeep = '0; a_s.tlast = 1'b0;
        a_s.tid = '0; a_s.tdest = '0; a_s.tuser = '0; a_m.tready = 1'b0;
        d_s.tvalid = 1'b0; d_s.tdata = '0; d_s.tkeep = '0; d_s.tlast = 1'b0;
        d_s.tid = '0; d_s.tdest = '0; d_s.tuser = '0; d_m.tready = 1'b1;
        r_s.tvalid = 1'b0; r_s.tdata = '0; r_s.tkeep = '0; r_s.tlast = 1'b0;
        r_s.tid = '0; r_s.tdest = '0; r_s.tuser = '0; r_m.tready = 1'b0;

        // Reset held for 10 cycles, then released between edges.
        repeat (10) begin
            @(negedge clk);
            check("reset_m_tvalid", a_m.tvalid, 1'b0);
            check("reset_s_tready", a_s.tready, 1'b0);
        end
        #1 rst = 1'b1;
        #1 check("release_s_tready_before_edge", a_s.tready, 1'b0);
        @(negedge clk);
        check("release_s_tready_a", a_s.tready, 1'b1);
        check("release_s_tready_r", r_s.tready, 1'b1);
        check("release_s_tready_d", d_s.tready, 1'b1);

        // Streaming: 16 back-to-back beats, each expected one edge after acceptance.
        @(posedge clk); #1;
        a_m.tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_a(make_a(32'(i), 4'(i), (i == 15), 8'(i), 8'(8'hF0 | i), 1'(i)), 1'b1);
        end
        a_s.tvalid = 1'b0;
        wait_drained("stream_drain_timeout");

        // Sideband pass-through with every field enabled.
        send_a(make_a(32'h1234_5678, 4'b0101, 1'b0, 8'd3, 8'd2, 1'b1), 1'b1);
        a_s.tvalid = 1'b0;
        wait_drained("sideband_drain_timeout");

        // Stall: 0xA5 parked on the output, 0x5A absorbed into skid.
        a_m.tready = 1'b0;
        send_a(make_a(32'hA5, 4'hF, 1'b0, 8'h01, 8'h01, 1'b0), 1'b0);
        send_a(make_a(32'h5A, 4'hF, 1'b1, 8'h02, 8'h02, 1'b1), 1'b0);
        a_s.tvalid = 1'b0;
        @(negedge clk);
        check("stall_s_tready_low", a_s.tready, 1'b0);
        check("stall_m_tvalid", a_m.tvalid, 1'b1);
        check("stall_m_tdata_hold", a_m.tdata, 32'hA5);
        repeat (3) @(negedge clk);
        check("stall_m_tdata_still", a_m.tdata, 32'hA5);
        check("stall_s_tready_still_low", a_s.tready, 1'b0);
        @(posedge clk); #1;
        a_m.tready = 1'b1;
        @(negedge clk);
        check("unstall_first_valid", a_m.tvalid, 1'b1);
        check("unstall_first_data", a_m.tdata, 32'hA5);
        @(negedge clk);
        check("unstall_second_valid", a_m.tvalid, 1'b1);
        check("unstall_second_data", a_m.tdata, 32'h5A);
        check("unstall_s_tready_back", a_s.tready, 1'b1);
        wait_drained("stall_drain_timeout");

        // Disabled sidebands are ignored on input and driven to constants on output.
        @(posedge clk); #1;
        send_d(make_a(32'hCAFE_F00D, 4'b0101, 1'b0, 8'd3, 8'd2, 1'b1),
               make_a(32'hCAFE_F00D, 4'hF, 1'b1, 8'd0, 8'd0, 1'b0));
        wait_drained("disabled_drain_timeout");

        // Random stress on the 128-bit slice with random valid gaps and backpressure.
        r_rand_en = 1'b1;
        for (int i = 0; i < N_RAND; i++) begin
            rb.data = {$urandom, $urandom, $urandom, $urandom};
            rb.keep = 16'($urandom);
            rb.last = (i == N_RAND - 1);
            rb.user = 1'($urandom);
            while ($urandom_range(0, 1) == 0) begin
                r_s.tvalid = 1'b0;
                @(posedge clk); #1;
            end
            send_r(rb);
        end
        r_s.tvalid = 1'b0;
        r_rand_en = 1'b0;
        r_m.tready = 1'b1;
        wait_drained("random_drain_timeout");
        check("random_beat_count", 128'(r_rcvd), 128'(N_RAND));
        check("random_final_tlast", r_last_seen, 1'b1);

        // Reset mid-stream with both stages occupied.
        @(posedge clk); #1;
        a_m.tready = 1'b0;
        send_a(make_a(32'h11, 4'hF, 1'b0, 8'h11, 8'h11, 1'b0), 1'b0);
        send_a(make_a(32'h22, 4'hF, 1'b0, 8'h22, 8'h22, 1'b0), 1'b0);
        a_s.tvalid = 1'b0;
        @(negedge clk);
        check("midreset_full_s_tready", a_s.tready, 1'b0);
        check("midreset_full_m_tvalid", a_m.tvalid, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("midreset_m_tvalid_async", a_m.tvalid, 1'b0);
        check("midreset_s_tready_async", a_s.tready, 1'b0);
        q_a.delete();
        repeat (3) @(negedge clk);
        a_m.tready = 1'b1;
        #1 rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("midreset_no_stale_beat", a_m.tvalid, 1'b0);
        end
        check("midreset_s_tready_after", a_s.tready, 1'b1);

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
